// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the byte-code fetch/decode front end and the
// execute stage it feeds: op encodings, FSM states, special bytes and
// small decode helpers.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ADDI  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    FETCH_IMM = 3'd2,
    ISSUE     = 3'd3,
    WAIT_EXEC = 3'd4,
    RELEASE   = 3'd5,
    HALT      = 3'd6
  } state_e;

  // The all-zero byte stops the machine until reset.
  localparam logic [7:0] HALT_BYTE = 8'h00;
  // Upper address bits of the data page that addr_out offsets into.
  localparam logic [2:0] DATA_PAGE = 3'b111;

  // Opcode field of an instruction byte.
  function automatic op_e byte_op(input logic [7:0] b);
    return op_e'(b[7:6]);
  endfunction

  // Ops whose execute result is written back into the accumulator.
  function automatic logic op_writes_acc(input op_e op);
    return (op == OP_LOAD) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus bundle between the fetch/decode block, instruction memory and the
// execute stage. master = fetch/decode side, slave = memory/execute side.
interface fetch_decode_if;
  import fetch_decode_pkg::*;

  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       exec_en;
  op_e        op;
  logic [7:0] val1;
  logic [7:0] val2;
  logic [4:0] addr_out;
  logic       exec_ready;
  logic [7:0] exec_val;

  modport master (
    output imem_addr, exec_en, op, val1, val2, addr_out,
    input  imem_data, exec_ready, exec_val
  );

  modport slave (
    input  imem_addr, exec_en, op, val1, val2, addr_out,
    output imem_data, exec_ready, exec_val
  );

endinterface

// File: rtl/fetch_decode_pc_counter.sv
// Program counter: load, increment, and wrap from PC_LAST back to PC_RESET.
// pc_d exposes the value pc takes at the next edge so the fetch address
// register can follow pc without a cycle of lag.
module pc_counter #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] PC_LAST  = 8'hDF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] pc,
  output logic [7:0] pc_d
);

  logic [7:0] pc_r;
  logic [7:0] pc_inc_s;
  logic [7:0] pc_d_s;

  // Wrapped successor of the current pc.
  always_comb begin
    pc_inc_s = pc_r + 8'd1;
    if (pc_r == PC_LAST) begin
      pc_inc_s = PC_RESET;
    end else begin
      pc_inc_s = pc_r + 8'd1;
    end
  end

  // Next pc: explicit load wins over increment.
  always_comb begin
    pc_d_s = pc_r;
    if (load) begin
      pc_d_s = load_val;
    end else if (inc) begin
      pc_d_s = pc_inc_s;
    end else begin
      pc_d_s = pc_r;
    end
  end

  // pc register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= PC_RESET;
    end else begin
      pc_r <= pc_d_s;
    end
  end

  assign pc   = pc_r;
  assign pc_d = pc_d_s;

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end for an 8-bit byte-code machine. Fetches one or two
// bytes per instruction from a fixed-latency instruction memory, hands
// LOAD/STORE/ADDI to the execute stage with a level handshake, and writes
// results back into the accumulator.
// Optional build macro BF8B_ILLEGAL_TRAP_EN: op-00 bytes other than HALT
// trap into HALT and raise the sticky err output (otherwise they are NOPs
// and err does not exist).
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [7:0] PC_LAST  = 8'hDF,
  parameter int         IMEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  fetch_decode_if.master       bus,
  output logic [7:0]           pc,
  output logic [7:0]           acc,
  output logic                 halted
`ifdef BF8B_ILLEGAL_TRAP_EN
  ,
  output logic                 err
`endif
);

  // The fetch cycle that captures imem_data is the one where the counter
  // has reached IMEM_LAT, i.e. IMEM_LAT full cycles after the address went out.
  localparam logic [1:0] LAT_LAST = 2'(IMEM_LAT);

  state_e     state_r;
  state_e     state_s;
  logic [1:0] lat_cnt_r;
  op_e        instr_op_r;
  logic [4:0] instr_addr_r;
  logic [7:0] acc_r;
  logic [7:0] val1_r;
  logic [7:0] val2_r;
  op_e        op_r;
  logic [4:0] addr_r;
  logic       exec_en_r;
  logic       halted_r;
  logic [7:0] imem_addr_r;
  logic [7:0] pc_s;
  logic [7:0] pc_d_s;
  logic       fetching_s;
  logic       fetch_done_s;
  logic       illegal_s;
  op_e        dec_op_s;
  logic [4:0] dec_addr_s;

  pc_counter #(
    .PC_RESET (PC_RESET),
    .PC_LAST  (PC_LAST)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (PC_RESET),
    .inc      (fetch_done_s),
    .pc       (pc_s),
    .pc_d     (pc_d_s)
  );

`ifdef BF8B_ILLEGAL_TRAP_EN
  assign illegal_s = (bus.imem_data[7:6] == OP_NOP) && (bus.imem_data[5:0] != 6'd0);
`else
  assign illegal_s = 1'b0;
`endif

  // Fetch progress and the op/addr fields that go out at issue time
  // (straight from memory for a one-byte op, from the latch for ADDI).
  always_comb begin
    fetching_s   = 1'b0;
    fetch_done_s = 1'b0;
    dec_op_s     = instr_op_r;
    dec_addr_s   = instr_addr_r;
    if ((state_r == FETCH) || (state_r == FETCH_IMM)) begin
      fetching_s = 1'b1;
    end else begin
      fetching_s = 1'b0;
    end
    if (fetching_s && (lat_cnt_r == LAT_LAST)) begin
      fetch_done_s = 1'b1;
    end else begin
      fetch_done_s = 1'b0;
    end
    if (state_r == FETCH) begin
      dec_op_s   = byte_op(bus.imem_data);
      dec_addr_s = bus.imem_data[4:0];
    end else begin
      dec_op_s   = instr_op_r;
      dec_addr_s = instr_addr_r;
    end
  end

  // Next-state logic; an instruction always runs to completion, run is
  // only consulted at instruction boundaries.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_s = FETCH;
        else     state_s = IDLE;
      end
      FETCH: begin
        if (!fetch_done_s) begin
          state_s = FETCH;
        end else if (bus.imem_data == HALT_BYTE) begin
          state_s = HALT;
        end else if (illegal_s) begin
          state_s = HALT;
        end else begin
          case (byte_op(bus.imem_data))
            OP_NOP:   state_s = run ? FETCH : IDLE;
            OP_ADDI:  state_s = FETCH_IMM;
            OP_LOAD:  state_s = ISSUE;
            OP_STORE: state_s = ISSUE;
            default:  state_s = IDLE;
          endcase
        end
      end
      FETCH_IMM: begin
        if (fetch_done_s) state_s = ISSUE;
        else              state_s = FETCH_IMM;
      end
      ISSUE: begin
        state_s = WAIT_EXEC;
      end
      WAIT_EXEC: begin
        if (bus.exec_ready) state_s = RELEASE;
        else                state_s = WAIT_EXEC;
      end
      RELEASE: begin
        if (run) state_s = FETCH;
        else     state_s = IDLE;
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Memory latency counter, restarted for every fetched byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_r <= 2'd0;
    end else if (fetching_s && !fetch_done_s) begin
      lat_cnt_r <= lat_cnt_r + 2'd1;
    end else begin
      lat_cnt_r <= 2'd0;
    end
  end

  // Fetch address follows pc (including the advance made this edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) imem_addr_r <= PC_RESET;
    else     imem_addr_r <= pc_d_s;
  end

  // First byte of an instruction, kept while the ADDI immediate is fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_op_r   <= OP_NOP;
      instr_addr_r <= 5'd0;
    end else if ((state_r == FETCH) && fetch_done_s) begin
      instr_op_r   <= byte_op(bus.imem_data);
      instr_addr_r <= bus.imem_data[4:0];
    end
  end

  // ADDI immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val2_r <= 8'h00;
    end else if ((state_r == FETCH_IMM) && fetch_done_s) begin
      val2_r <= bus.imem_data;
    end
  end

  // Issue operands, set on entry to ISSUE so they lead exec_en by a cycle
  // and stay frozen for the whole handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_NOP;
      addr_r <= 5'd0;
      val1_r <= 8'h00;
    end else if ((state_s == ISSUE) && (state_r != ISSUE)) begin
      op_r   <= dec_op_s;
      addr_r <= dec_addr_s;
      val1_r <= acc_r;
    end
  end

  // Accumulator write-back on the completing exec_ready edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 8'h00;
    end else if ((state_r == WAIT_EXEC) && bus.exec_ready && op_writes_acc(op_r)) begin
      acc_r <= bus.exec_val;
    end
  end

  // Registered status strobes decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_en_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      exec_en_r <= (state_s == WAIT_EXEC);
      halted_r  <= (state_s == HALT);
    end
  end

`ifdef BF8B_ILLEGAL_TRAP_EN
  logic err_r;

  // Sticky illegal-op flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == FETCH) && fetch_done_s && illegal_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`endif

  assign bus.imem_addr = imem_addr_r;
  assign bus.exec_en   = exec_en_r;
  assign bus.op        = op_r;
  assign bus.val1      = val1_r;
  assign bus.val2      = val2_r;
  assign bus.addr_out  = addr_r;
  assign pc            = pc_s;
  assign acc           = acc_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed testbench for fetch_decode (default parameters, IMEM_LAT=2).
// Instruction memory: 256-byte array behind a two-stage read pipeline.
// Execute stage: exec_ready = ready_force | (ready_auto & exec_en).
`timescale 1ns/1ps
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] pc;
  logic [7:0] acc;
  logic       halted;
`ifdef BF8B_ILLEGAL_TRAP_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] pipe0;
  logic [7:0] pipe1;
  logic       ready_force = 1'b0;
  logic       ready_auto  = 1'b1;
  logic [7:0] exec_val_drv = 8'h00;

  fetch_decode_if bus();

  always #5 clk = ~clk;

  fetch_decode #(
    .PC_RESET (8'h00),
    .PC_LAST  (8'hDF),
    .IMEM_LAT (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .acc    (acc),
    .halted (halted)
`ifdef BF8B_ILLEGAL_TRAP_EN
    ,
    .err    (err)
`endif
  );

  // Instruction memory with two cycles of read latency.
  always @(posedge clk) begin
    pipe0 <= mem[bus.imem_addr];
    pipe1 <= pipe0;
  end
  assign bus.imem_data  = pipe1;
  assign bus.exec_ready = ready_force | (ready_auto & bus.exec_en);
  assign bus.exec_val   = exec_val_drv;

  // Handshake monitor: pulse count, shortest low gap, operand stability.
  int   pulses = 0, min_gap = 1000, low_cnt = 0, unstable = 0;
  int   clr_req = 0, clr_ack = 0;
  logic seen = 1'b0, prev_en = 1'b0;
  op_e  prev_op;
  logic [7:0] prev_v1, prev_v2;
  logic [4:0] prev_addr;
  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      pulses = 0; min_gap = 1000; low_cnt = 0; unstable = 0; seen = 1'b0;
      clr_ack = clr_req;
    end else if (bus.exec_en === 1'b1) begin
      if (prev_en !== 1'b1) begin
        pulses++;
        if (seen && (low_cnt < min_gap)) min_gap = low_cnt;
        seen = 1'b1;
        low_cnt = 0;
      end else if ((bus.op !== prev_op) || (bus.val1 !== prev_v1) ||
                   (bus.val2 !== prev_v2) || (bus.addr_out !== prev_addr)) begin
        unstable++;
      end
    end else begin
      low_cnt++;
    end
    prev_en = bus.exec_en; prev_op = bus.op; prev_v1 = bus.val1;
    prev_v2 = bus.val2; prev_addr = bus.addr_out;
  end

  task automatic clear_mon();
    clr_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_clean(input logic [7:0] fill);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; ready_force = 1'b0; ready_auto = 1'b1; exec_val_drv = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = fill;
    clear_mon();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({pc, acc, bus.imem_addr} !== 24'h000000) begin
      errors++; $display("FAIL reset_regs pc/acc/imem_addr=%h want 000000", {pc, acc, bus.imem_addr});
    end
    checks++;
    if ({bus.exec_en, halted, bus.op, bus.addr_out, bus.val2} !== 17'd0) begin
      errors++; $display("FAIL reset_outs en/halt/op/addr/val2=%h want 0",
                         {bus.exec_en, halted, bus.op, bus.addr_out, bus.val2});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({pc, bus.imem_addr, bus.exec_en} !== 17'd0) begin
      errors++; $display("FAIL idle_hold pc/imem_addr/en=%h want 0", {pc, bus.imem_addr, bus.exec_en});
    end
  endtask

  task automatic test_load();
    op_e last_op;
    start_clean(8'h80);
    mem[0] = 8'h41; exec_val_drv = 8'h5A; run = 1'b1;
    last_op = bus.op;
    for (int i = 0; i < 20; i++) begin
      if (bus.exec_en === 1'b1) break;
      last_op = bus.op;
      @(negedge clk);
    end
    checks++;
    if (bus.exec_en !== 1'b1) begin errors++; $display("FAIL load_timeout exec_en=%b want 1", bus.exec_en); end
    checks++;
    if (last_op !== OP_LOAD) begin errors++; $display("FAIL load_op_lead op_before_en=%0d want 1", last_op); end
    checks++;
    if ({bus.op, bus.addr_out} !== {OP_LOAD, 5'd1}) begin
      errors++; $display("FAIL load_decode op=%0d addr=%0d want 1 1", bus.op, bus.addr_out);
    end
    run = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL load_pulses got %0d want 1", pulses); end
    checks++;
    if ({acc, pc} !== 16'h5A01) begin errors++; $display("FAIL load_result acc/pc=%h want 5a01", {acc, pc}); end
  endtask

  task automatic test_addi_halt();
    start_clean(8'h80);
    mem[0] = 8'h41; mem[1] = 8'hC0; mem[2] = 8'h07; mem[3] = 8'h00;
    exec_val_drv = 8'h03; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.exec_en === 1'b1) break;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (acc !== 8'h03) begin errors++; $display("FAIL addi_preload acc=%h want 03", acc); end
    exec_val_drv = 8'h0A;
    for (int i = 0; i < 30; i++) begin
      if (bus.exec_en === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if ({bus.exec_en, bus.op, bus.val1, bus.val2} !== {1'b1, OP_ADDI, 8'h03, 8'h07}) begin
      errors++; $display("FAIL addi_issue en=%b op=%0d val1=%h val2=%h want 1 3 03 07",
                         bus.exec_en, bus.op, bus.val1, bus.val2);
    end
    for (int i = 0; i < 40; i++) begin
      if (halted === 1'b1) break;
      @(negedge clk);
    end
    // Program starts with the LOAD that sets acc=3, so HALT sits at address 3.
    checks++;
    if ({halted, acc, pc, bus.exec_en} !== {1'b1, 8'h0A, 8'h04, 1'b0}) begin
      errors++; $display("FAIL addi_halt halted=%b acc=%h pc=%h en=%b want 1 0a 04 0",
                         halted, acc, pc, bus.exec_en);
    end
    ready_force = 1'b1; exec_val_drv = 8'hFF;
    repeat (8) @(negedge clk);
    checks++;
    if ({halted, acc, pc, bus.exec_en} !== {1'b1, 8'h0A, 8'h04, 1'b0}) begin
      errors++; $display("FAIL halt_sticky halted=%b acc=%h pc=%h en=%b want 1 0a 04 0",
                         halted, acc, pc, bus.exec_en);
    end
    checks++;
    if ({pulses, unstable} !== {32'd2, 32'd0}) begin
      errors++; $display("FAIL addi_pulses pulses=%0d unstable=%0d want 2 0", pulses, unstable);
    end
  endtask

  task automatic test_back_to_back();
    start_clean(8'h80);
    mem[0] = 8'h85; mem[1] = 8'h86; mem[2] = 8'h00;
    exec_val_drv = 8'hEE; ready_force = 1'b1; run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (halted === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++;
    if (min_gap < 1) begin errors++; $display("FAIL b2b_gap got %0d want >=1", min_gap); end
    checks++;
    if ({acc, bus.addr_out, pc, halted} !== {8'h00, 5'd6, 8'h03, 1'b1}) begin
      errors++; $display("FAIL b2b_state acc=%h addr=%0d pc=%h halted=%b want 00 6 03 1",
                         acc, bus.addr_out, pc, halted);
    end
  endtask

  task automatic test_wrap();
    start_clean(8'h80);
    mem[0] = 8'h9F; mem[8'hDF] = 8'hC0;
    exec_val_drv = 8'h33; run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ((bus.exec_en === 1'b1) && (bus.op === OP_ADDI)) break;
      @(negedge clk);
    end
    checks++;
    if ((bus.exec_en !== 1'b1) || (bus.op !== OP_ADDI)) begin
      errors++; $display("FAIL wrap_timeout en=%b op=%0d want 1 3", bus.exec_en, bus.op);
    end
    checks++;
    if ({bus.val2, pc, bus.imem_addr} !== 24'h9F0101) begin
      errors++; $display("FAIL wrap_imm val2/pc/imem_addr=%h want 9f0101", {bus.val2, pc, bus.imem_addr});
    end
    @(negedge clk);
    checks++;
    if (acc !== 8'h33) begin errors++; $display("FAIL wrap_acc acc=%h want 33", acc); end
    run = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_clean(8'h80);
    mem[0] = 8'h81; ready_auto = 1'b0; run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.exec_en === 1'b1) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.exec_en, pc} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL mid_wait en=%b pc=%h want 1 01", bus.exec_en, pc);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.exec_en, pc, bus.imem_addr, acc} !== 25'd0) begin
      errors++; $display("FAIL mid_async en=%b pc=%h imem_addr=%h acc=%h want 0 00 00 00",
                         bus.exec_en, pc, bus.imem_addr, acc);
    end
    @(negedge clk);
    ready_auto = 1'b1;
    clear_mon();
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL mid_refetch imem_addr=%h want 00", bus.imem_addr); end
    for (int i = 0; i < 20; i++) begin
      if (bus.exec_en === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if ({bus.exec_en, bus.op, bus.addr_out} !== {1'b1, OP_STORE, 5'd1}) begin
      errors++; $display("FAIL mid_reissue en=%b op=%0d addr=%0d want 1 2 1", bus.exec_en, bus.op, bus.addr_out);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_illegal();
    start_clean(8'h80);
    mem[0] = 8'h05; mem[1] = 8'h00; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (halted === 1'b1) break;
      @(negedge clk);
    end
`ifdef BF8B_ILLEGAL_TRAP_EN
    checks++;
    if ({halted, err, pc} !== {1'b1, 1'b1, 8'h01}) begin
      errors++; $display("FAIL illegal_trap halted=%b err=%b pc=%h want 1 1 01", halted, err, pc);
    end
`else
    checks++;
    if ({halted, pc} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL illegal_nop halted=%b pc=%h want 1 02", halted, pc);
    end
`endif
    checks++;
    if ({pulses, 31'd0, bus.exec_en} !== 64'd0) begin
      errors++; $display("FAIL illegal_noexec pulses=%0d en=%b want 0 0", pulses, bus.exec_en);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_addi_halt();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
